// File: rtl/garbage_collector.sv
// Garbage-collection engine: tracks page validity and block usage, picks the
// least-valid used block, relocates its live pages, erases it and frees it.
module garbage_collector #(
    parameter int NBLK    = 16,
    parameter int PPB     = 8,
    parameter int LOW_WM  = 4,
    parameter int CRIT_WM = 1,
    localparam int BW = $clog2(NBLK),
    localparam int PW = $clog2(PPB),
    localparam int CW = $clog2(NBLK + 1)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          gc_ini,
    input  logic          gc_start,
    output logic          gc_request,
    output logic          gc_interrupt,
    output logic          req_done,
    input  logic [BW-1:0] active_blk,
    input  logic          blk_alloc,
    input  logic [BW-1:0] blk_alloc_id,
    input  logic          pg_wr,
    input  logic [BW-1:0] pg_wr_blk,
    input  logic [PW-1:0] pg_wr_page,
    input  logic          pg_inv,
    input  logic [BW-1:0] pg_inv_blk,
    input  logic [PW-1:0] pg_inv_page,
    output logic          mv_req,
    output logic [BW-1:0] mv_blk,
    output logic [PW-1:0] mv_page,
    input  logic          mv_ack,
    output logic          erase_req,
    output logic [BW-1:0] erase_blk,
    input  logic          erase_ack
);

    localparam logic [CW-1:0] LOW_C    = CW'(LOW_WM);
    localparam logic [CW-1:0] CRIT_C   = CW'(CRIT_WM);
    localparam logic [CW-1:0] FULL_C   = CW'(NBLK);
    localparam logic [BW-1:0] LAST_BLK = BW'(NBLK - 1);
    localparam logic [PW-1:0] LAST_PG  = PW'(PPB - 1);

    typedef enum logic [2:0] {IDLE, REQ, SCAN, MOVE, ERASE, DONE} state_t;

    state_t                     state_q, state_d;
    logic [NBLK-1:0][PPB-1:0]   valid_q, valid_d;
    logic [NBLK-1:0]            used_q, used_d;
    logic [CW-1:0]              free_cnt_q, free_cnt_d;
    logic [BW-1:0]              scan_idx_q, scan_idx_d;
    logic [BW-1:0]              victim_q, victim_d;
    logic [PW:0]                best_cnt_q, best_cnt_d;
    logic                       found_q, found_d;
    logic [PW-1:0]              page_ptr_q, page_ptr_d;
    logic                       mv_req_q, mv_req_d;
    logic                       erase_req_q, erase_req_d;
    logic                       gc_request_q, gc_request_d;
    logic                       gc_interrupt_q, gc_interrupt_d;

    logic                       alloc_ok;
    logic                       erase_done;
    logic                       advance;
    logic [PW:0]                scan_cnt;

    function automatic logic [PW:0] popcount(input logic [PPB-1:0] bits);
        logic [PW:0] cnt;
        cnt = '0;
        for (int i = 0; i < PPB; i++) begin
            cnt = cnt + (PW+1)'(bits[i]);
        end
        return cnt;
    endfunction

    // Bookkeeping runs in every state; the FSM layers relocation and erase on
    // top of it, and gc_ini finally overrides everything back to the init state.
    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        used_d         = used_q;
        scan_idx_d     = scan_idx_q;
        victim_d       = victim_q;
        best_cnt_d     = best_cnt_q;
        found_d        = found_q;
        page_ptr_d     = page_ptr_q;
        mv_req_d       = mv_req_q;
        erase_req_d    = erase_req_q;
        erase_done     = 1'b0;
        advance        = 1'b0;
        alloc_ok       = blk_alloc && !used_q[blk_alloc_id];
        scan_cnt       = popcount(valid_q[scan_idx_q]);

        if (pg_inv) valid_d[pg_inv_blk][pg_inv_page] = 1'b0;
        if (pg_wr)  valid_d[pg_wr_blk][pg_wr_page]   = 1'b1;
        if (alloc_ok) used_d[blk_alloc_id] = 1'b1;

        case (state_q)
            IDLE: begin
                if (free_cnt_q < LOW_C) state_d = REQ;
            end
            REQ: begin
                if (gc_start) begin
                    state_d    = SCAN;
                    scan_idx_d = '0;
                    found_d    = 1'b0;
                    best_cnt_d = '0;
                    victim_d   = '0;
                end
            end
            SCAN: begin
                if (used_q[scan_idx_q] && (scan_idx_q != active_blk) &&
                    (!found_q || (scan_cnt < best_cnt_q))) begin
                    found_d    = 1'b1;
                    victim_d   = scan_idx_q;
                    best_cnt_d = scan_cnt;
                end
                scan_idx_d = scan_idx_q + BW'(1);
                if (scan_idx_q == LAST_BLK) begin
                    page_ptr_d = '0;
                    state_d    = found_d ? MOVE : DONE;
                end
            end
            MOVE: begin
                // An outstanding request is never retracted, even if its page is invalidated.
                if (mv_req_q) begin
                    if (mv_ack) begin
                        mv_req_d = 1'b0;
                        valid_d[victim_q][page_ptr_q] = 1'b0;
                        advance  = 1'b1;
                    end
                end else if (valid_q[victim_q][page_ptr_q]) begin
                    mv_req_d = 1'b1;
                end else begin
                    advance = 1'b1;
                end
                if (advance) begin
                    if (page_ptr_q == LAST_PG) state_d = ERASE;
                    else page_ptr_d = page_ptr_q + PW'(1);
                end
            end
            ERASE: begin
                if (erase_req_q) begin
                    if (erase_ack) begin
                        erase_req_d       = 1'b0;
                        valid_d[victim_q] = '0;
                        used_d[victim_q]  = 1'b0;
                        erase_done        = 1'b1;
                        state_d           = DONE;
                    end
                end else begin
                    erase_req_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        free_cnt_d     = free_cnt_q - CW'(alloc_ok) + CW'(erase_done);
        gc_request_d   = (state_q == REQ);
        gc_interrupt_d = (free_cnt_q <= CRIT_C);

        if (gc_ini) begin
            state_d        = IDLE;
            valid_d        = '0;
            used_d         = '0;
            free_cnt_d     = FULL_C;
            scan_idx_d     = '0;
            victim_d       = '0;
            best_cnt_d     = '0;
            found_d        = 1'b0;
            page_ptr_d     = '0;
            mv_req_d       = 1'b0;
            erase_req_d    = 1'b0;
            gc_request_d   = 1'b0;
            gc_interrupt_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= IDLE;
            valid_q        <= '0;
            used_q         <= '0;
            free_cnt_q     <= FULL_C;
            scan_idx_q     <= '0;
            victim_q       <= '0;
            best_cnt_q     <= '0;
            found_q        <= 1'b0;
            page_ptr_q     <= '0;
            mv_req_q       <= 1'b0;
            erase_req_q    <= 1'b0;
            gc_request_q   <= 1'b0;
            gc_interrupt_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            valid_q        <= valid_d;
            used_q         <= used_d;
            free_cnt_q     <= free_cnt_d;
            scan_idx_q     <= scan_idx_d;
            victim_q       <= victim_d;
            best_cnt_q     <= best_cnt_d;
            found_q        <= found_d;
            page_ptr_q     <= page_ptr_d;
            mv_req_q       <= mv_req_d;
            erase_req_q    <= erase_req_d;
            gc_request_q   <= gc_request_d;
            gc_interrupt_q <= gc_interrupt_d;
        end
    end

    assign gc_request   = gc_request_q;
    assign gc_interrupt = gc_interrupt_q;
    assign req_done     = (state_q == DONE);
    assign mv_req       = mv_req_q;
    assign mv_blk       = mv_req_q ? victim_q : '0;
    assign mv_page      = mv_req_q ? page_ptr_q : '0;
    assign erase_req    = erase_req_q;
    assign erase_blk    = erase_req_q ? victim_q : '0;

endmodule

// File: tb/tb_garbage_collector.sv
// Self-checking bench for garbage_collector: vector table for request/interrupt
// levels, directed GC passes, and randomized passes against a block/page model.
module tb_garbage_collector;

    localparam int NBLK = 16;
    localparam int PPB  = 8;
    localparam int BW   = 4;
    localparam int PW   = 3;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          gc_ini = 1'b0;
    logic          gc_start = 1'b0;
    logic          gc_request;
    logic          gc_interrupt;
    logic          req_done;
    logic [BW-1:0] active_blk = '0;
    logic          blk_alloc = 1'b0;
    logic [BW-1:0] blk_alloc_id = '0;
    logic          pg_wr = 1'b0;
    logic [BW-1:0] pg_wr_blk = '0;
    logic [PW-1:0] pg_wr_page = '0;
    logic          pg_inv = 1'b0;
    logic [BW-1:0] pg_inv_blk = '0;
    logic [PW-1:0] pg_inv_page = '0;
    logic          mv_req;
    logic [BW-1:0] mv_blk;
    logic [PW-1:0] mv_page;
    logic          mv_ack = 1'b0;
    logic          erase_req;
    logic [BW-1:0] erase_blk;
    logic          erase_ack = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    bit [PPB-1:0] modelValid [NBLK];
    bit           modelUsed  [NBLK];

    typedef struct {
        logic          alloc;
        logic [BW-1:0] allocId;
        logic          expReq;
        logic          expInt;
    } vecT;

    vecT vecs [17];

    garbage_collector dut (
        .CLK(CLK), .nRST(nRST), .gc_ini(gc_ini), .gc_start(gc_start),
        .gc_request(gc_request), .gc_interrupt(gc_interrupt), .req_done(req_done),
        .active_blk(active_blk), .blk_alloc(blk_alloc), .blk_alloc_id(blk_alloc_id),
        .pg_wr(pg_wr), .pg_wr_blk(pg_wr_blk), .pg_wr_page(pg_wr_page),
        .pg_inv(pg_inv), .pg_inv_blk(pg_inv_blk), .pg_inv_page(pg_inv_page),
        .mv_req(mv_req), .mv_blk(mv_blk), .mv_page(mv_page), .mv_ack(mv_ack),
        .erase_req(erase_req), .erase_blk(erase_blk), .erase_ack(erase_ack)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input vecT v);
        blk_alloc    = v.alloc;
        blk_alloc_id = v.allocId;
        tick();
        blk_alloc    = 1'b0;
    endtask

    function automatic int modelFree();
        int n = 0;
        for (int b = 0; b < NBLK; b++) if (!modelUsed[b]) n++;
        return n;
    endfunction

    // Least-valid used block that is not open for writes; strict '<' keeps the lowest index on ties.
    function automatic int chooseVictim(input int act);
        int best = -1;
        int bestCnt = PPB + 1;
        for (int b = 0; b < NBLK; b++) begin
            if (modelUsed[b] && b != act && $countones(modelValid[b]) < bestCnt) begin
                best = b;
                bestCnt = $countones(modelValid[b]);
            end
        end
        return best;
    endfunction

    function automatic int lowestSet(input logic [PPB-1:0] m);
        for (int i = 0; i < PPB; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic pickOutput(input int which);
        case (which)
            0: return gc_request;
            1: return mv_req;
            2: return erase_req;
            default: return req_done;
        endcase
    endfunction

    task automatic waitOutput(input int which, input int budget, input string name);
        int n = 0;
        while (pickOutput(which) !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, pickOutput(which), 1);
    endtask

    task automatic doInit();
        gc_ini = 1'b1;
        tick();
        gc_ini = 1'b0;
        for (int b = 0; b < NBLK; b++) begin
            modelValid[b] = '0;
            modelUsed[b]  = 1'b0;
        end
    endtask

    task automatic allocBlock(input int b);
        blk_alloc = 1'b1;
        blk_alloc_id = b[BW-1:0];
        tick();
        blk_alloc = 1'b0;
        modelUsed[b] = 1'b1;
    endtask

    task automatic writePage(input int b, input int p);
        pg_wr = 1'b1; pg_wr_blk = b[BW-1:0]; pg_wr_page = p[PW-1:0];
        tick();
        pg_wr = 1'b0;
        modelValid[b][p] = 1'b1;
    endtask

    task automatic invPage(input int b, input int p);
        pg_inv = 1'b1; pg_inv_blk = b[BW-1:0]; pg_inv_page = p[PW-1:0];
        tick();
        pg_inv = 1'b0;
        modelValid[b][p] = 1'b0;
    endtask

    // Grants one GC pass and services it, checking victim, page order, erase and done pulse.
    task automatic runGcPass(input int victim, input logic [PPB-1:0] expPages,
                             input int invPg, input int allocAtErase);
        logic [PPB-1:0] remaining = expPages;
        int  mvCount = 0;
        int  cycles = 0;
        int  expPage;
        bit  invDone = 1'b0;
        waitOutput(0, 60, "gcRequestUp");
        gc_start = 1'b1;
        tick();
        gc_start = 1'b0;
        tick();
        checkOutput("gcRequestDrop", gc_request, 0);
        while (erase_req !== 1'b1 && cycles < 500) begin
            if (mv_req === 1'b1) begin
                expPage = lowestSet(remaining);
                mvCount++;
                checkOutput("mvBlk", mv_blk, victim);
                checkOutput("mvPage", mv_page, expPage);
                if (expPage >= 0) remaining[expPage] = 1'b0;
                if (invPg >= 0 && !invDone) begin
                    invPage(victim, invPg);
                    invDone = 1'b1;
                end
                repeat ($urandom_range(0, 2)) tick();
                checkOutput("mvHeld", {mv_req, 1'b0, mv_page}, {1'b1, 1'b0, expPage[PW-1:0]});
                mv_ack = 1'b1;
                tick();
                mv_ack = 1'b0;
                checkOutput("mvReqDrop", mv_req, 0);
                cycles += 4;
            end else begin
                tick();
                cycles++;
            end
        end
        checkOutput("mvCount", mvCount, $countones(expPages));
        checkOutput("eraseReq", erase_req, 1);
        checkOutput("eraseBlk", erase_blk, victim);
        repeat ($urandom_range(0, 3)) tick();
        checkOutput("eraseHeld", erase_req, 1);
        erase_ack = 1'b1;
        if (allocAtErase >= 0) begin
            blk_alloc = 1'b1;
            blk_alloc_id = allocAtErase[BW-1:0];
        end
        tick();
        erase_ack = 1'b0;
        blk_alloc = 1'b0;
        checkOutput("reqDone", req_done, 1);
        checkOutput("eraseDrop", erase_req, 0);
        tick();
        checkOutput("reqDonePulse", req_done, 0);
        if (victim >= 0) begin
            modelValid[victim] = '0;
            modelUsed[victim]  = 1'b0;
        end
        if (allocAtErase >= 0) modelUsed[allocAtErase] = 1'b1;
    endtask

    task automatic postCheck();
        repeat (3) tick();
        checkOutput("gcRequestLevel", gc_request, modelFree() < 4);
        checkOutput("gcInterruptLevel", gc_interrupt, modelFree() <= 1);
    endtask

    initial begin
        int highCount;
        int order [NBLK];
        int nUsed, act, victim, allocAtErase, tmp, j, p;
        logic [PPB-1:0] mask;

        for (int i = 0; i < 17; i++) begin
            vecs[i].alloc   = (i < 16);
            vecs[i].allocId = (i < 15) ? BW'(i) : BW'(3);
            vecs[i].expReq  = (i >= 14);
            vecs[i].expInt  = (i >= 15);
        end

        // Reset: outputs quiet during and after reset, no spurious request.
        #12;
        checkOutput("rstReq", gc_request, 0);
        checkOutput("rstInt", gc_interrupt, 0);
        checkOutput("rstDone", req_done, 0);
        checkOutput("rstMv", {mv_req, mv_blk, mv_page}, 0);
        checkOutput("rstErase", {erase_req, erase_blk}, 0);
        #5;
        nRST = 1'b1;
        highCount = 0;
        repeat (100) begin
            tick();
            if (gc_request !== 1'b0) highCount++;
        end
        checkOutput("idleNoRequest", highCount, 0);

        // Allocation sweep: request two cycles after the 13th alloc, interrupt when critical.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vecReq%0d", i), gc_request, vecs[i].expReq);
            checkOutput($sformatf("vecInt%0d", i), gc_interrupt, vecs[i].expInt);
        end

        // Victim choice with a tie between blocks 3 and 7.
        doInit();
        active_blk = BW'(12);
        for (int b = 0; b <= 12; b++) allocBlock(b);
        for (int b = 0; b <= 12; b++)
            for (int pg = 0; pg < PPB; pg++)
                if ((b == 3) ? (pg == 1 || pg == 5) : (b == 7) ? (pg == 2 || pg == 6) : 1'b1)
                    writePage(b, pg);
        checkOutput("modelVictimTie", chooseVictim(12), 3);
        runGcPass(3, 8'b0010_0010, -1, -1);
        postCheck();

        // Empty victim, active block excluded: block 1 erased with no relocations.
        doInit();
        active_blk = BW'(0);
        for (int b = 0; b <= 12; b++) allocBlock(b);
        runGcPass(1, 8'h00, -1, -1);
        postCheck();

        // Page 5 invalidated while page 1 awaits its ack: only one relocation.
        doInit();
        active_blk = BW'(12);
        for (int b = 0; b <= 12; b++) allocBlock(b);
        for (int b = 0; b <= 12; b++) begin
            if (b == 4) begin
                writePage(b, 1);
                writePage(b, 5);
            end else begin
                writePage(b, 0);
                writePage(b, 2);
                writePage(b, 3);
            end
        end
        runGcPass(4, 8'b0000_0010, 5, -1);
        postCheck();

        // gc_ini in the middle of a relocation.
        doInit();
        active_blk = BW'(12);
        for (int b = 0; b <= 12; b++) allocBlock(b);
        for (int b = 0; b <= 12; b++) writePage(b, 0);
        waitOutput(0, 60, "midReqUp");
        gc_start = 1'b1;
        tick();
        gc_start = 1'b0;
        waitOutput(1, 80, "midMvReq");
        checkOutput("midMvBlk", mv_blk, 0);
        doInit();
        checkOutput("iniReq", gc_request, 0);
        checkOutput("iniInt", gc_interrupt, 0);
        checkOutput("iniDone", req_done, 0);
        checkOutput("iniMv", {mv_req, mv_blk, mv_page}, 0);
        checkOutput("iniErase", {erase_req, erase_blk}, 0);
        for (int b = 0; b < 12; b++) allocBlock(b);
        repeat (4) tick();
        checkOutput("iniFreeFour", gc_request, 0);
        allocBlock(12);
        tick();
        checkOutput("iniReqLatency1", gc_request, 0);
        tick();
        checkOutput("iniReqLatency2", gc_request, 1);

        // Randomized passes against the model.
        for (int it = 0; it < 6; it++) begin
            doInit();
            for (int b = 0; b < NBLK; b++) order[b] = b;
            for (int b = NBLK - 1; b > 0; b--) begin
                j = $urandom_range(0, b);
                tmp = order[b]; order[b] = order[j]; order[j] = tmp;
            end
            nUsed = $urandom_range(13, 15);
            for (int k = 0; k < nUsed; k++) allocBlock(order[k]);
            for (int k = 0; k < nUsed; k++) begin
                mask = PPB'($urandom);
                for (int pg = 0; pg < PPB; pg++) if (mask[pg]) writePage(order[k], pg);
            end
            repeat (4) invPage(order[$urandom_range(0, nUsed - 1)], $urandom_range(0, PPB - 1));
            p = $urandom_range(0, PPB - 1);
            pg_wr = 1'b1; pg_wr_blk = order[0][BW-1:0]; pg_wr_page = p[PW-1:0];
            pg_inv = 1'b1; pg_inv_blk = order[0][BW-1:0]; pg_inv_page = p[PW-1:0];
            tick();
            pg_wr = 1'b0;
            pg_inv = 1'b0;
            modelValid[order[0]][p] = 1'b1;
            act = order[$urandom_range(0, nUsed - 1)];
            active_blk = act[BW-1:0];
            victim = chooseVictim(act);
            allocAtErase = (nUsed < NBLK && $urandom_range(0, 1) == 1) ? order[nUsed] : -1;
            runGcPass(victim, modelValid[victim], -1, allocAtErase);
            postCheck();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
